// File: rtl/fx2_cmd_parser_pkg.sv
// Shared constants, FSM state type and helpers for the FX2 command parser.
// Register address constants mirror the fx2_timetag register map.
package fx2_cmd_parser_pkg;

  localparam logic [7:0] CMD_MAGIC = 8'hAA;
  localparam logic [7:0] CMD_RD    = 8'h00;
  localparam logic [7:0] CMD_WR    = 8'h01;

  localparam logic [15:0] REG_VERSION      = 16'd1;
  localparam logic [15:0] REG_CLOCKRATE    = 16'd2;
  localparam logic [15:0] REG_CAPTURE_CTRL = 16'd3;
  localparam logic [15:0] REG_STROBE_EN    = 16'd4;
  localparam logic [15:0] REG_DELTA_EN     = 16'd5;

  localparam int unsigned ACK_TIMEOUT_DEF = 64;
  localparam int unsigned PKT_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RW,
    ST_ADDR,
    ST_VAL,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_REPLY
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fx2_cmd_parser_if.sv
// Command stream, register bus and reply stream of the FX2 command parser.
// The parser uses the slave view; the surrounding FIFO/register logic uses master.
interface fx2_cmd_parser_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [7:0]  reply_data;
  logic        reply_valid;
  logic        reply_ready;
  logic [7:0]  err_count;

  modport master (
    output in_data, in_valid, reg_rdata, reg_ack, reply_ready,
    input  in_ready, reg_addr, reg_wdata, reg_wr, reg_rd, reply_data, reply_valid, err_count
  );

  modport slave (
    input  in_data, in_valid, reg_rdata, reg_ack, reply_ready,
    output in_ready, reg_addr, reg_wdata, reg_wr, reg_rd, reply_data, reply_valid, err_count
  );
endinterface

// File: rtl/fx2_reply_ser.sv
// 32-bit word to byte-stream serializer with valid/ready handshake, LSB first.
// 'last' flags the handshake that consumes the final byte of the word.
module fx2_reply_ser (
  input  logic        fx2_clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        ready,
  output logic [7:0]  data,
  output logic        valid,
  output logic        last
);
  logic [31:0] shreg;
  logic [2:0]  left;

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      left  <= '0;
    end else if (load) begin
      shreg <= load_data;
      left  <= 3'd4;
    end else if (valid && ready) begin
      shreg <= {8'h00, shreg[31:8]};
      left  <= left - 3'd1;
    end
  end

  assign valid = (left != 3'd0);
  assign data  = shreg[7:0];
  assign last  = valid && ready && (left == 3'd1);

endmodule

// File: rtl/fx2_cmd_parser.sv
// Frames 8-byte register packets from the FX2 OUT-FIFO, performs one register
// bus access per packet and streams the 32-bit result back to the IN-FIFO.
module fx2_cmd_parser
  import fx2_cmd_parser_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned PKT_TIMEOUT = PKT_TIMEOUT_DEF
) (
  input logic             fx2_clk,
  input logic             reset_n,
  fx2_cmd_parser_if.slave bus
);
  localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);
  localparam logic [15:0] PKT_LIMIT = 16'(PKT_TIMEOUT - 1);

  state_t      state, state_next;
  logic [2:0]  byte_cnt;
  logic        is_write;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] ack_cnt;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_q;
  logic        in_pkt, accept, rw_ok, waiting;
  logic        pkt_expired, ack_expired;
  logic        ser_load, ser_last, err_inc;
  logic [31:0] ser_load_data;

  assign in_pkt      = (state == ST_RW) || (state == ST_ADDR) || (state == ST_VAL);
  assign accept      = bus.in_valid && (in_pkt || (state == ST_IDLE));
  assign rw_ok       = (bus.in_data == CMD_RD) || (bus.in_data == CMD_WR);
  assign waiting     = (state == ST_ISSUE) || (state == ST_WAIT_ACK);
  assign pkt_expired = in_pkt && !accept && (pkt_cnt >= PKT_LIMIT);
  assign ack_expired = (state == ST_WAIT_ACK) && !bus.reg_ack && (ack_cnt >= ACK_LIMIT);

  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (accept && bus.in_data == CMD_MAGIC) state_next = ST_RW;
      ST_RW: begin
        if (accept)           state_next = rw_ok ? ST_ADDR : ST_IDLE;
        else if (pkt_expired) state_next = ST_IDLE;
      end
      ST_ADDR: begin
        if (accept && byte_cnt == 3'd1) state_next = ST_VAL;
        else if (pkt_expired)           state_next = ST_IDLE;
      end
      ST_VAL: begin
        if (accept && byte_cnt == 3'd3) state_next = ST_ISSUE;
        else if (pkt_expired)           state_next = ST_IDLE;
      end
      // An ack arriving together with the strobe skips the wait entirely.
      ST_ISSUE:    state_next = bus.reg_ack ? ST_REPLY : ST_WAIT_ACK;
      ST_WAIT_ACK: if (bus.reg_ack || ack_expired) state_next = ST_REPLY;
      ST_REPLY:    if (ser_last) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = in_pkt || (state == ST_IDLE);
    bus.reg_rd    = (state == ST_ISSUE) && !is_write;
    bus.reg_wr    = (state == ST_ISSUE) && is_write;
    ser_load      = waiting && (bus.reg_ack || ack_expired);
    ser_load_data = bus.reg_ack ? bus.reg_rdata : 32'hFFFF_FFFF;
    err_inc       = pkt_expired || ack_expired || ((state == ST_RW) && accept && !rw_ok);
  end

  // Address and value bytes shift in from the top so the first byte ends up least significant.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      is_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pkt_cnt  <= '0;
      ack_cnt  <= '0;
      err_q    <= '0;
    end else begin
      if (state_next != state)
        byte_cnt <= '0;
      else if (accept && (state == ST_ADDR || state == ST_VAL))
        byte_cnt <= byte_cnt + 3'd1;
      if (accept && state == ST_RW)   is_write <= (bus.in_data == CMD_WR);
      if (accept && state == ST_ADDR) addr_q   <= {bus.in_data, addr_q[15:8]};
      if (accept && state == ST_VAL)  wdata_q  <= {bus.in_data, wdata_q[31:8]};
      pkt_cnt <= (in_pkt && !accept) ? pkt_cnt + 16'd1 : '0;
      ack_cnt <= (state == ST_ISSUE)    ? 16'd1 :
                 (state == ST_WAIT_ACK) ? ack_cnt + 16'd1 : '0;
      if (err_inc) err_q <= sat_inc(err_q);
    end
  end

  fx2_reply_ser u_reply_ser (
    .fx2_clk   (fx2_clk),
    .reset_n   (reset_n),
    .load      (ser_load),
    .load_data (ser_load_data),
    .ready     (bus.reply_ready),
    .data      (bus.reply_data),
    .valid     (bus.reply_valid),
    .last      (ser_last)
  );

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.err_count = err_q;

endmodule
